// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between instruction fetch, the prefetch
// queue and the decode stage.
//   push_*  : fetch side pushes {pc, instr} under push_valid/push_ready
//   pop_*   : decode side pops the head entry under pop_valid/pop_ready
//   flush   : branch/jump resolution, empties the queue
//   count   : number of stored entries
// Modports: slave = the queue, master = the fetch/decode environment.
interface fetch_queue_if #(
  parameter int N  = 32,
  parameter int AW = 2
);
  logic         push_valid;
  logic         push_ready;
  logic [N-1:0] push_pc;
  logic [N-1:0] push_instr;
  logic         pop_valid;
  logic         pop_ready;
  logic [N-1:0] pop_pc;
  logic [N-1:0] pop_pc_plus4;
  logic [N-1:0] pop_instr;
  logic         flush;
  logic [AW:0]  count;

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready, flush,
    output push_ready, pop_valid, pop_pc, pop_pc_plus4, pop_instr, count
  );

  modport master (
    output push_valid, push_pc, push_instr, pop_ready, flush,
    input  push_ready, pop_valid, pop_pc, pop_pc_plus4, pop_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between instruction-memory fetch and
// the IF/ID decode stage. First-word-fall-through head, no same-cycle bypass;
// decode sees NOP (0) when the queue is empty or being flushed.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   bus         fetch_queue_if.slave (push/pop handshakes, flush, count)
//   flush_drops (only with FETCH_QUEUE_STATS_EN) saturating sum of count
//               sampled at every flush edge
// Optional feature macro: FETCH_QUEUE_STATS_EN
module fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   flush_drops
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [N-1:0]  last_pc_q, last_pc_d;
  logic          not_empty;
  logic          push_fire, pop_fire;

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

  // Handshake outputs; flush blocks both sides for the whole cycle.
  assign bus.push_ready = (count_q != FULL) && !bus.flush;
  assign bus.pop_valid  = not_empty && !bus.flush;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign pop_fire       = bus.pop_valid && bus.pop_ready;

  // Head outputs. When empty the storage slot under rd_ptr is stale, so the
  // PC comes from a register holding the most recently popped PC instead.
  assign bus.pop_pc       = not_empty ? head.pc : last_pc_q;
  assign bus.pop_pc_plus4 = bus.pop_pc + N'(4);
  assign bus.pop_instr    = bus.pop_valid ? head.instr : '0;
  assign bus.count        = count_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH == 2**AW.
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        last_pc_d = head.pc;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Storage has no reset; contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (reset && push_fire) mem_q[wr_ptr_q] <= '{pc: bus.push_pc, instr: bus.push_instr};
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] drops_q;
  logic [16:0] drops_sum;

  assign drops_sum   = {1'b0, drops_q} + 17'(count_q);
  assign flush_drops = drops_q;

  always_ff @(posedge clk) begin
    if (!reset)         drops_q <= '0;
    else if (bus.flush) drops_q <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
  end
`endif

endmodule
